// File: rtl/alu_mdu.sv
// Registered ALU with iterative shift-add multiply and restoring divide.
// One request is in flight at a time; the result is held until the response handshake.
module alu_mdu #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [15:0]      alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Result_hi,
    output logic             Zero
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opb;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;

    function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [SHW-1:0]          shamt;
    logic [WIDTH-1:0]        alu_res;

    assign a_s   = A;
    assign b_s   = B;
    assign shamt = A[SHW-1:0];

    // Exact one-hot matches only; zero or multi-bit opcodes fall to the default of 0.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            16'h0001: alu_res = A + B;
            16'h0002: alu_res = A - B;
            16'h0004: alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            16'h0008: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            16'h0010: alu_res = A & B;
            16'h0020: alu_res = ~(A | B);
            16'h0040: alu_res = A | B;
            16'h0080: alu_res = A ^ B;
            16'h0100: alu_res = B << shamt;
            16'h0200: alu_res = B >> shamt;
            16'h0400: alu_res = b_s >>> shamt;
            16'h0800: alu_res = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default:  alu_res = '0;
        endcase
    end

    logic is_mdu;
    logic op_div;
    logic signed_op;
    logic sa;
    logic sb;

    assign is_mdu    = (alu_op == 16'h1000) || (alu_op == 16'h2000) ||
                       (alu_op == 16'h4000) || (alu_op == 16'h8000);
    assign op_div    = (alu_op == 16'h4000) || (alu_op == 16'h8000);
    assign signed_op = (alu_op == 16'h1000) || (alu_op == 16'h4000);
    assign sa        = signed_op & A[WIDTH-1];
    assign sb        = signed_op & B[WIDTH-1];

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH-1:0] prod_fix;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opb};
    assign div_sub   = WIDTH'(div_shift - {1'b0, opb});
    // A zero divisor leaves |A| in the remainder, so only the quotient needs forcing.
    assign quo_fix   = div_zero ? '1 : cneg(acc_lo, neg_q);
    assign rem_fix   = cneg(acc_hi, neg_r);
    assign prod_fix  = cneg2({acc_hi, acc_lo}, neg_q);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            Result    <= '0;
            Result_hi <= '0;
            Zero      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_mdu) begin
                            is_div   <= op_div;
                            neg_q    <= sa ^ sb;
                            neg_r    <= sa;
                            div_zero <= (B == '0);
                            acc_hi   <= '0;
                            acc_lo   <= op_div ? cneg(A, sa) : cneg(B, sb);
                            opb      <= op_div ? cneg(B, sb) : cneg(A, sa);
                            cnt      <= (SHW+1)'(WIDTH);
                            state    <= BUSY;
                        end else begin
                            Result    <= alu_res;
                            Result_hi <= '0;
                            Zero      <= (alu_res == '0);
                            state     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - (SHW+1)'(1);
                        if (is_div) begin
                            acc_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                        end else begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
                    end else begin
                        if (is_div) begin
                            Result    <= quo_fix;
                            Result_hi <= rem_fix;
                            Zero      <= (quo_fix == '0);
                        end else begin
                            Result    <= prod_fix[WIDTH-1:0];
                            Result_hi <= prod_fix[2*WIDTH-1:WIDTH];
                            Zero      <= (prod_fix[WIDTH-1:0] == '0);
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
